// File: rtl/reg_bank_sb_if.sv
// Bus bundle for the register bank: write port, two read ports, the reserve
// strobe and the scoreboard summary. The master side is whoever drives the
// bank (control unit or testbench); the slave side is the bank itself.
interface reg_bank_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              rd1_en;
   logic [ADDR_W-1:0] rd1_addr;
   logic [DATA_W-1:0] rd1_data;
   logic              rd1_busy;

   logic              rd2_en;
   logic [ADDR_W-1:0] rd2_addr;
   logic [DATA_W-1:0] rd2_data;
   logic              rd2_busy;

   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;

   logic              busy_any;

   modport master (
      output wr_en, wr_addr, wr_data,
      output rd1_en, rd1_addr,
      output rd2_en, rd2_addr,
      output rsv_en, rsv_addr,
      input  rd1_data, rd1_busy,
      input  rd2_data, rd2_busy,
      input  busy_any
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  rd1_en, rd1_addr,
      input  rd2_en, rd2_addr,
      input  rsv_en, rsv_addr,
      output rd1_data, rd1_busy,
      output rd2_data, rd2_busy,
      output busy_any
   );

endinterface

// File: rtl/reg_bank_sb.sv
// Register bank with one synchronous write port, two combinational read
// ports with write-through bypass, and a per-register busy scoreboard used
// by multi-cycle units to reserve a destination register. Disabled read
// ports and reset force the outputs to zero rather than floating them.
module reg_bank_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input logic        clk,
   input logic        rst,
   reg_bank_sb_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic              wr_ok;
   logic              rsv_ok;
   logic [DEPTH-1:0]  wr_sel;
   logic [DEPTH-1:0]  rsv_sel;

   logic              rd_en   [2];
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   // Register 0 is hard-wired when ZERO_REG is set: never written, never busy.
   function automatic logic is_locked(input logic [ADDR_W-1:0] addr);
      return ZERO_REG && (addr == '0);
   endfunction

   assign wr_ok  = bus.wr_en  && !is_locked(bus.wr_addr);
   assign rsv_ok = bus.rsv_en && !is_locked(bus.rsv_addr);

   // One-hot decode of the write and reserve targets for the scoreboard update.
   always_comb begin
      wr_sel  = '0;
      rsv_sel = '0;
      if (wr_ok) begin
         wr_sel[bus.wr_addr] = 1'b1;
      end
      if (rsv_ok) begin
         rsv_sel[bus.rsv_addr] = 1'b1;
      end
   end

   // Data array: reset clears every entry, otherwise the write port lands here.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Scoreboard: a write clears its target, a reservation sets its target, and
   // the reservation is applied last so it wins when both hit the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~wr_sel) | rsv_sel;
      end
   end

   assign rd_en[0]   = bus.rd1_en;
   assign rd_addr[0] = bus.rd1_addr;
   assign rd_en[1]   = bus.rd2_en;
   assign rd_addr[1] = bus.rd2_addr;

   // Both read ports share one lookup: disabled, reset or locked reads give zero,
   // a matching in-flight write is forwarded with busy already cleared.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (!rst && rd_en[p] && !is_locked(rd_addr[p])) begin
            if (bus.wr_en && (bus.wr_addr == rd_addr[p])) begin
               rd_data[p] = bus.wr_data;
            end else begin
               rd_data[p] = regs[rd_addr[p]];
               rd_busy[p] = busy[rd_addr[p]];
            end
         end
      end
   end

   assign bus.rd1_data = rd_data[0];
   assign bus.rd1_busy = rd_busy[0];
   assign bus.rd2_data = rd_data[1];
   assign bus.rd2_busy = rd_busy[1];
   assign bus.busy_any = !rst && (|busy);

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: a 16-bit/8-entry bank and a 32-bit/32-entry bank with
// register 0 hard-wired, both compared every cycle against an array model.
module tb_reg_bank_sb;

   logic clk;
   logic rst;

   reg_bank_sb_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
   reg_bank_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

   reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   reg_bank_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   logic        s_rst;
   logic        s_wr_en   [2];
   logic [4:0]  s_wr_addr [2];
   logic [31:0] s_wr_data [2];
   logic        s_rd1_en  [2];
   logic [4:0]  s_rd1_addr[2];
   logic        s_rd2_en  [2];
   logic [4:0]  s_rd2_addr[2];
   logic        s_rsv_en  [2];
   logic [4:0]  s_rsv_addr[2];

   logic [31:0] m_regs [2][32];
   bit          m_busy [2][32];

   int total;
   int bad;

   assign rst           = s_rst;
   assign bus0.wr_en    = s_wr_en[0];
   assign bus0.wr_addr  = s_wr_addr[0][2:0];
   assign bus0.wr_data  = s_wr_data[0][15:0];
   assign bus0.rd1_en   = s_rd1_en[0];
   assign bus0.rd1_addr = s_rd1_addr[0][2:0];
   assign bus0.rd2_en   = s_rd2_en[0];
   assign bus0.rd2_addr = s_rd2_addr[0][2:0];
   assign bus0.rsv_en   = s_rsv_en[0];
   assign bus0.rsv_addr = s_rsv_addr[0][2:0];
   assign bus1.wr_en    = s_wr_en[1];
   assign bus1.wr_addr  = s_wr_addr[1];
   assign bus1.wr_data  = s_wr_data[1];
   assign bus1.rd1_en   = s_rd1_en[1];
   assign bus1.rd1_addr = s_rd1_addr[1];
   assign bus1.rd2_en   = s_rd2_en[1];
   assign bus1.rd2_addr = s_rd2_addr[1];
   assign bus1.rsv_en   = s_rsv_en[1];
   assign bus1.rsv_addr = s_rsv_addr[1];

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int depth_of(input int k);
      return (k == 0) ? 8 : 32;
   endfunction

   function automatic logic [31:0] mask_of(input int k);
      return (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic bit hardwired(input int k, input logic [4:0] a);
      return (k == 1) && (a == 5'd0);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // What a read port should show right now, from the array contents and the
   // current write strobe.
   task automatic modelRead(input int k, input logic en, input logic [4:0] a,
                            output logic [31:0] d, output logic b);
      d = 32'h0;
      b = 1'b0;
      if (!s_rst && en && !hardwired(k, a)) begin
         if (s_wr_en[k] && s_wr_addr[k] == a) begin
            d = s_wr_data[k] & mask_of(k);
         end else begin
            d = m_regs[k][a];
            b = m_busy[k][a];
         end
      end
   endtask

   task automatic compareInst(input int k, input logic [31:0] d1, input logic b1,
                              input logic [31:0] d2, input logic b2, input logic ba);
      logic [31:0] ed;
      logic        eb;
      bit          any;
      modelRead(k, s_rd1_en[k], s_rd1_addr[k], ed, eb);
      checkOutput($sformatf("i%0d rd1_data a=%0d", k, s_rd1_addr[k]), 64'(d1), 64'(ed));
      checkOutput($sformatf("i%0d rd1_busy a=%0d", k, s_rd1_addr[k]), 64'(b1), 64'(eb));
      modelRead(k, s_rd2_en[k], s_rd2_addr[k], ed, eb);
      checkOutput($sformatf("i%0d rd2_data a=%0d", k, s_rd2_addr[k]), 64'(d2), 64'(ed));
      checkOutput($sformatf("i%0d rd2_busy a=%0d", k, s_rd2_addr[k]), 64'(b2), 64'(eb));
      any = 1'b0;
      for (int i = 0; i < depth_of(k); i++) begin
         any |= m_busy[k][i];
      end
      checkOutput($sformatf("i%0d busy_any", k), 64'(ba), 64'(any && !s_rst));
   endtask

   task automatic modelUpdate();
      for (int k = 0; k < 2; k++) begin
         if (s_rst) begin
            for (int i = 0; i < 32; i++) begin
               m_regs[k][i] = 32'h0;
               m_busy[k][i] = 1'b0;
            end
         end else begin
            if (s_wr_en[k] && !hardwired(k, s_wr_addr[k])) begin
               m_regs[k][s_wr_addr[k]] = s_wr_data[k] & mask_of(k);
               m_busy[k][s_wr_addr[k]] = 1'b0;
            end
            if (s_rsv_en[k] && !hardwired(k, s_rsv_addr[k])) begin
               m_busy[k][s_rsv_addr[k]] = 1'b1;
            end
         end
      end
   endtask

   task automatic waitSample();
      @(negedge clk);
      compareInst(0, 32'(bus0.rd1_data), bus0.rd1_busy, 32'(bus0.rd2_data), bus0.rd2_busy, bus0.busy_any);
      compareInst(1, bus1.rd1_data, bus1.rd1_busy, bus1.rd2_data, bus1.rd2_busy, bus1.busy_any);
   endtask

   task automatic advance();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic applyStimulus();
      waitSample();
      advance();
   endtask

   task automatic setIdle();
      s_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         s_wr_en[k]    = 1'b0;
         s_wr_addr[k]  = 5'd0;
         s_wr_data[k]  = 32'h0;
         s_rd1_en[k]   = 1'b0;
         s_rd1_addr[k] = 5'd0;
         s_rd2_en[k]   = 1'b0;
         s_rd2_addr[k] = 5'd0;
         s_rsv_en[k]   = 1'b0;
         s_rsv_addr[k] = 5'd0;
      end
   endtask

   task automatic randomCycle();
      s_rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
         int span;
         span = (k == 1 && $urandom_range(0, 3) == 0) ? 31 : 7;
         s_wr_en[k]    = $urandom_range(0, 1) == 1;
         s_wr_addr[k]  = 5'($urandom_range(0, span));
         s_wr_data[k]  = $urandom();
         s_rd1_en[k]   = $urandom_range(0, 3) != 0;
         s_rd1_addr[k] = 5'($urandom_range(0, span));
         s_rd2_en[k]   = $urandom_range(0, 3) != 0;
         s_rd2_addr[k] = 5'($urandom_range(0, span));
         s_rsv_en[k]   = $urandom_range(0, 2) == 0;
         s_rsv_addr[k] = 5'($urandom_range(0, span));
      end
   endtask

   // Directed scenarios first, then a long randomized run against the model.
   initial begin
      total = 0;
      bad   = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[k][i] = 32'h0;
            m_busy[k][i] = 1'b0;
         end
      end
      setIdle();
      s_rst = 1'b1;
      applyStimulus();
      applyStimulus();
      s_rst = 1'b0;

      for (int a = 0; a < 8; a++) begin
         s_rd1_en[0] = 1'b1; s_rd1_addr[0] = 5'(a);
         s_rd2_en[0] = 1'b1; s_rd2_addr[0] = 5'(a);
         s_rd1_en[1] = 1'b1; s_rd1_addr[1] = 5'(a + 24);
         waitSample();
         checkOutput("reset rd1_data", 64'(bus0.rd1_data), 64'h0);
         checkOutput("reset rd2_busy", 64'(bus0.rd2_busy), 64'h0);
         checkOutput("reset busy_any", 64'(bus0.busy_any), 64'h0);
         advance();
      end

      setIdle();
      s_wr_en[0] = 1'b1; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'hA5A5;
      s_rd1_en[0] = 1'b1; s_rd1_addr[0] = 5'd3;
      waitSample();
      checkOutput("bypass r3", 64'(bus0.rd1_data), 64'hA5A5);
      advance();
      s_wr_en[0] = 1'b0;
      waitSample();
      checkOutput("array r3", 64'(bus0.rd1_data), 64'hA5A5);
      advance();

      setIdle();
      s_rsv_en[0] = 1'b1; s_rsv_addr[0] = 5'd5;
      s_rd2_en[0] = 1'b1; s_rd2_addr[0] = 5'd5;
      applyStimulus();
      s_rsv_en[0] = 1'b0;
      waitSample();
      checkOutput("rsv r5 busy", 64'(bus0.rd2_busy), 64'h1);
      checkOutput("rsv busy_any", 64'(bus0.busy_any), 64'h1);
      advance();
      applyStimulus();
      s_wr_en[0] = 1'b1; s_wr_addr[0] = 5'd5; s_wr_data[0] = 32'h1234;
      waitSample();
      checkOutput("clear r5 busy", 64'(bus0.rd2_busy), 64'h0);
      checkOutput("clear r5 data", 64'(bus0.rd2_data), 64'h1234);
      checkOutput("busy_any still", 64'(bus0.busy_any), 64'h1);
      advance();
      s_wr_en[0] = 1'b0;
      waitSample();
      checkOutput("busy_any clear", 64'(bus0.busy_any), 64'h0);
      advance();

      setIdle();
      s_wr_en[0] = 1'b1; s_wr_addr[0] = 5'd2; s_wr_data[0] = 32'h00FF;
      s_rsv_en[0] = 1'b1; s_rsv_addr[0] = 5'd2;
      applyStimulus();
      setIdle();
      s_rd1_en[0] = 1'b1; s_rd1_addr[0] = 5'd2;
      waitSample();
      checkOutput("wr+rsv data", 64'(bus0.rd1_data), 64'h00FF);
      checkOutput("wr+rsv busy", 64'(bus0.rd1_busy), 64'h1);
      advance();

      setIdle();
      s_wr_en[0] = 1'b1; s_wr_addr[0] = 5'd1; s_wr_data[0] = 32'hFFFF;
      s_wr_en[1] = 1'b1; s_wr_addr[1] = 5'd0; s_wr_data[1] = 32'hBEEF;
      s_rd1_en[1] = 1'b1; s_rd1_addr[1] = 5'd0;
      waitSample();
      checkOutput("r0 bypass", 64'(bus1.rd1_data), 64'h0);
      advance();
      setIdle();
      s_rd1_en[0] = 1'b0; s_rd1_addr[0] = 5'd1;
      s_rd1_en[1] = 1'b1; s_rd1_addr[1] = 5'd0;
      waitSample();
      checkOutput("disabled data", 64'(bus0.rd1_data), 64'h0);
      checkOutput("disabled busy", 64'(bus0.rd1_busy), 64'h0);
      checkOutput("r0 array", 64'(bus1.rd1_data), 64'h0);
      advance();

      setIdle();
      for (int a = 1; a < 8; a++) begin
         s_wr_en[0] = 1'b1; s_wr_addr[0] = 5'(a); s_wr_data[0] = 32'(16'h1100 * a);
         applyStimulus();
      end
      setIdle();
      s_rsv_en[0] = 1'b1; s_rsv_addr[0] = 5'd4;
      applyStimulus();
      setIdle();
      s_rst = 1'b1;
      applyStimulus();
      s_rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         s_rd1_en[0] = 1'b1; s_rd1_addr[0] = 5'(a);
         s_rd2_en[0] = 1'b1; s_rd2_addr[0] = 5'(a);
         waitSample();
         checkOutput("post-rst data", 64'(bus0.rd1_data), 64'h0);
         checkOutput("post-rst busy_any", 64'(bus0.busy_any), 64'h0);
         advance();
      end

      setIdle();
      s_wr_en[1] = 1'b1; s_wr_addr[1] = 5'd31; s_wr_data[1] = 32'hDEADBEEF;
      applyStimulus();
      setIdle();
      s_rd2_en[1] = 1'b1; s_rd2_addr[1] = 5'd31;
      waitSample();
      checkOutput("r31 wide", 64'(bus1.rd2_data), 64'hDEADBEEF);
      advance();

      for (int n = 0; n < 1500; n++) begin
         randomCycle();
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
